// File: rtl/pong_pkg.sv
// Shared pong datapath definitions: FSM encoding, paddle action codes and
// velocity-width defaults reused by the ball position integrator.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_LEFT  = 2'b01;
  localparam logic [1:0] ACT_RIGHT = 2'b10;

  localparam int VEL_W_DEFAULT     = 4;
  localparam int MAX_SPEED_DEFAULT = 7;

  // Paddle motion as a signed -1/0/+1 step; code 11 behaves like no motion.
  function automatic logic signed [1:0] action_delta(input logic [1:0] act);
    case (act)
      ACT_LEFT:  return -2'sd1;
      ACT_RIGHT: return 2'sd1;
      default:   return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Signed VW-bit add of a small -1/0/+1 step, clamped to +/-MAX_SPEED.
module sat_add_signed #(
  parameter int VW        = 4,
  parameter int MAX_SPEED = 7
) (
  input  logic signed [VW-1:0] a,
  input  logic signed [1:0]    b,
  output logic signed [VW-1:0] y
);

  localparam logic signed [VW:0] MAX_P = MAX_SPEED[VW:0];
  localparam logic signed [VW:0] MAX_N = -MAX_P;

  logic signed [VW:0] sum;

  // One guard bit keeps the raw sum exact before clamping.
  always_comb begin
    sum = {a[VW-1], a} + {{(VW-1){b[1]}}, b};
    if (sum > MAX_P) begin
      y = MAX_P[VW-1:0];
    end else if (sum < MAX_N) begin
      y = MAX_N[VW-1:0];
    end else begin
      y = sum[VW-1:0];
    end
  end

endmodule

// File: rtl/ball_velocity_ctrl.sv
// Ball velocity engine: serve/play/hold FSM, wall and paddle reflection,
// paddle english, rally counting and per-level vertical speed-up.
module ball_velocity_ctrl
  import pong_pkg::*;
#(
  parameter int VW             = VEL_W_DEFAULT,
  parameter int MAX_SPEED      = MAX_SPEED_DEFAULT,
  parameter int START_SPEED    = 1,
  parameter int HITS_PER_LEVEL = 4,
  parameter int HOLDOFF        = 2,
  parameter int CW             = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serve,
  input  logic [1:0]           serve_dir,
  input  logic                 miss,
  input  logic                 hit_top,
  input  logic                 hit_bottom,
  input  logic                 wall_left,
  input  logic                 wall_right,
  input  logic [1:0]           action_top,
  input  logic [1:0]           action_bottom,
  output logic signed [VW-1:0] vel_x,
  output logic signed [VW-1:0] vel_y,
  output logic [CW-1:0]        rally_count,
  output logic [1:0]           state
);

  localparam int LW        = $clog2(HITS_PER_LEVEL + 1);
  localparam int HW        = $clog2(HOLDOFF + 1);
  localparam int LVL_LAST  = HITS_PER_LEVEL - 1;
  localparam int HOLD_LAST = HOLDOFF - 1;
  localparam logic signed [VW-1:0] START = START_SPEED[VW-1:0];

  state_e                state_q, state_d;
  logic signed [VW-1:0]  vx_q, vx_d, vy_q, vy_d;
  logic [CW-1:0]         rally_q, rally_d;
  logic [LW-1:0]         level_q, level_d;
  logic [HW-1:0]         hold_q, hold_d;

  logic                  wall_hit, top_ok, bot_ok, paddle_hit;
  logic [1:0]            act;
  logic signed [1:0]     act_delta, step_dir;
  logic signed [VW-1:0]  vx_wall, vx_paddle, vy_neg, vy_step;

  // Direction-valid qualification; the wall flip feeds the paddle adjustment.
  always_comb begin
    wall_hit   = (wall_left && vx_q[VW-1]) ||
                 (wall_right && (vx_q != '0) && !vx_q[VW-1]);
    vx_wall    = wall_hit ? -vx_q : vx_q;
    top_ok     = hit_top && vy_q[VW-1];
    bot_ok     = hit_bottom && (vy_q != '0) && !vy_q[VW-1];
    paddle_hit = (state_q == PLAY) && (top_ok || bot_ok);
    act        = top_ok ? action_top : action_bottom;
    act_delta  = action_delta(act);
    vy_neg     = -vy_q;
    step_dir   = vy_neg[VW-1] ? -2'sd1 : 2'sd1;
  end

  sat_add_signed #(.VW(VW), .MAX_SPEED(MAX_SPEED)) u_action (
    .a(vx_wall),
    .b(act_delta),
    .y(vx_paddle)
  );

  sat_add_signed #(.VW(VW), .MAX_SPEED(MAX_SPEED)) u_speed (
    .a(vy_neg),
    .b(step_dir),
    .y(vy_step)
  );

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    rally_d = rally_q;
    level_d = level_q;
    hold_d  = hold_q;
    if (miss) begin
      state_d = IDLE;
      vx_d    = '0;
      vy_d    = '0;
      rally_d = '0;
      level_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          vx_d = '0;
          vy_d = '0;
          if (serve) begin
            vy_d    = serve_dir[1] ? START : -START;
            vx_d    = serve_dir[0] ? START : -START;
            rally_d = '0;
            level_d = '0;
            hold_d  = '0;
            state_d = PLAY;
          end
        end
        PLAY, HOLD: begin
          vx_d = vx_wall;
          if (paddle_hit) begin
            vx_d    = vx_paddle;
            vy_d    = vy_neg;
            rally_d = (rally_q == '1) ? rally_q : rally_q + 1'b1;
            if (level_q == LVL_LAST[LW-1:0]) begin
              level_d = '0;
              vy_d    = vy_step;
            end else begin
              level_d = level_q + 1'b1;
            end
            hold_d  = '0;
            state_d = HOLD;
          end else if (state_q == HOLD) begin
            // Paddle strobes stay blocked through the final hold-off cycle.
            if (hold_q == HOLD_LAST[HW-1:0]) begin
              hold_d  = '0;
              state_d = PLAY;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vx_q    <= '0;
      vy_q    <= '0;
      rally_q <= '0;
      level_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      rally_q <= rally_d;
      level_q <= level_d;
      hold_q  <= hold_d;
    end
  end

  assign vel_x       = vx_q;
  assign vel_y       = vy_q;
  assign rally_count = rally_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ball_velocity_ctrl.sv
// Scoreboard bench for ball_velocity_ctrl: directed rally scenarios plus
// random strobes, checked against an integer reference model of the rules.
module tb_ball_velocity_ctrl;
  import pong_pkg::*;

  localparam int VW      = 4;
  localparam int MAXS    = 7;
  localparam int START   = 1;
  localparam int HPL     = 4;
  localparam int HOLDOFF = 2;
  localparam int CW      = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic serve = 1'b0;
  logic [1:0] serve_dir = 2'b00;
  logic miss = 1'b0, hit_top = 1'b0, hit_bottom = 1'b0;
  logic wall_left = 1'b0, wall_right = 1'b0;
  logic [1:0] action_top = 2'b00, action_bottom = 2'b00;
  logic signed [VW-1:0] vel_x, vel_y;
  logic [CW-1:0] rally_count;
  logic [1:0] state;

  typedef struct packed {
    bit       serve;
    bit [1:0] dir;
    bit       miss;
    bit       ht;
    bit       hb;
    bit       wl;
    bit       wr;
    bit [1:0] at;
    bit [1:0] ab;
  } stim_t;

  typedef struct {
    int vx;
    int vy;
    int rally;
    int st;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_fail = 0;

  // Reference model state: mode 0 idle, 1 play, 2 hold.
  int m_vx, m_vy, m_rally, m_level, m_hold, m_mode;

  ball_velocity_ctrl #(
    .VW(VW), .MAX_SPEED(MAXS), .START_SPEED(START),
    .HITS_PER_LEVEL(HPL), .HOLDOFF(HOLDOFF), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .serve(serve), .serve_dir(serve_dir),
    .miss(miss), .hit_top(hit_top), .hit_bottom(hit_bottom),
    .wall_left(wall_left), .wall_right(wall_right),
    .action_top(action_top), .action_bottom(action_bottom),
    .vel_x(vel_x), .vel_y(vel_y), .rally_count(rally_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > MAXS) return MAXS;
    if (v < -MAXS) return -MAXS;
    return v;
  endfunction

  function automatic void model_reset();
    m_vx = 0; m_vy = 0; m_rally = 0; m_level = 0; m_hold = 0; m_mode = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    int nvx, nvy, act;
    bit top_ok, bot_ok;
    if (s.miss) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (s.serve) begin
        m_vy = s.dir[1] ? START : -START;
        m_vx = s.dir[0] ? START : -START;
        m_rally = 0; m_level = 0; m_mode = 1;
      end
      return;
    end
    nvx = m_vx;
    nvy = m_vy;
    if ((s.wl && m_vx < 0) || (s.wr && m_vx > 0)) nvx = -m_vx;
    top_ok = s.ht && (m_vy < 0);
    bot_ok = s.hb && (m_vy > 0);
    if (m_mode == 1 && (top_ok || bot_ok)) begin
      act = top_ok ? int'(s.at) : int'(s.ab);
      if (act == 1) nvx = clamp(nvx - 1);
      else if (act == 2) nvx = clamp(nvx + 1);
      nvy = -m_vy;
      m_level++;
      if (m_level == HPL) begin
        m_level = 0;
        nvy = (nvy > 0) ? clamp(nvy + 1) : clamp(nvy - 1);
      end
      if (m_rally < (1 << CW) - 1) m_rally++;
      m_mode = 2;
      m_hold = HOLDOFF;
    end else if (m_mode == 2) begin
      m_hold--;
      if (m_hold == 0) m_mode = 1;
    end
    m_vx = nvx;
    m_vy = nvy;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the model's view of the next edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    serve = s.serve; serve_dir = s.dir; miss = s.miss;
    hit_top = s.ht; hit_bottom = s.hb; wall_left = s.wl; wall_right = s.wr;
    action_top = s.at; action_bottom = s.ab;
    model_step(s);
    e.vx = m_vx; e.vy = m_vy; e.rally = m_rally; e.st = m_mode;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t serve_stim(input bit [1:0] dir);
    stim_t s;
    s = '0;
    s.serve = 1'b1;
    s.dir = dir;
    return s;
  endfunction

  // Strobe whichever paddle the ball is currently heading towards.
  function automatic stim_t hit_stim(input bit [1:0] act);
    stim_t s;
    s = '0;
    if (m_vy < 0) s.ht = 1'b1;
    else s.hb = 1'b1;
    s.at = act;
    s.ab = act;
    return s;
  endfunction

  task automatic zero_inputs();
    serve = 0; serve_dir = 0; miss = 0; hit_top = 0; hit_bottom = 0;
    wall_left = 0; wall_right = 0; action_top = 0; action_bottom = 0;
  endtask

  task automatic check_cleared(input string tag);
    checkOutput({tag, "_vel_x"}, int'(vel_x), 0);
    checkOutput({tag, "_vel_y"}, int'(vel_y), 0);
    checkOutput({tag, "_rally"}, int'(rally_count), 0);
    checkOutput({tag, "_state"}, int'(state), 0);
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sb_vel_x", int'(vel_x), e.vx);
        checkOutput("sb_vel_y", int'(vel_y), e.vy);
        checkOutput("sb_rally", int'(rally_count), e.rally);
        checkOutput("sb_state", int'(state), e.st);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    #3;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(serve_stim(2'b10));
    checkOutput("serve_vel_y", int'(vel_y), 1);
    checkOutput("serve_vel_x", int'(vel_x), -1);
    checkOutput("serve_state", int'(state), 1);
    checkOutput("serve_rally", int'(rally_count), 0);

    s = idle_stim(); s.miss = 1'b1;
    applyStimulus(s);
    applyStimulus(serve_stim(2'b11));
    s = idle_stim(); s.hb = 1'b1; s.ab = ACT_RIGHT;
    applyStimulus(s);
    checkOutput("hit1_vel_x", int'(vel_x), 2);
    checkOutput("hit1_vel_y", int'(vel_y), -1);
    checkOutput("hit1_rally", int'(rally_count), 1);
    checkOutput("hit1_state", int'(state), 2);
    s = idle_stim(); s.hb = 1'b1;
    applyStimulus(s);
    checkOutput("hold1_state", int'(state), 2);
    checkOutput("hold1_vel_y", int'(vel_y), -1);
    s = idle_stim(); s.ht = 1'b1; s.at = ACT_RIGHT;
    applyStimulus(s);
    checkOutput("hold_end_state", int'(state), 1);
    checkOutput("hold_end_vel_y", int'(vel_y), -1);
    checkOutput("hold_end_rally", int'(rally_count), 1);

    // Hits 2..7 with right english: vel_x climbs to +7 and stays there.
    for (int h = 2; h <= 7; h++) begin
      applyStimulus(hit_stim(ACT_RIGHT));
      if (h == 4) checkOutput("level_vel_y", int'(vel_y), 2);
      if (h == 7) checkOutput("sat_vel_x", int'(vel_x), 7);
      applyStimulus(idle_stim());
      applyStimulus(idle_stim());
    end
    s = hit_stim(ACT_RIGHT); s.wr = 1'b1;
    applyStimulus(s);
    checkOutput("wall_paddle_vel_x", int'(vel_x), -6);
    checkOutput("wall_paddle_rally", int'(rally_count), 8);

    s = idle_stim(); s.miss = 1'b1; s.serve = 1'b1; s.dir = 2'b11;
    applyStimulus(s);
    check_cleared("miss_hold");

    applyStimulus(serve_stim(2'b10));
    s = idle_stim(); s.ht = 1'b1; s.at = ACT_RIGHT;
    applyStimulus(s);
    checkOutput("bad_top_vel_y", int'(vel_y), 1);
    checkOutput("bad_top_state", int'(state), 1);
    s = idle_stim(); s.ht = 1'b1; s.hb = 1'b1; s.at = ACT_LEFT; s.ab = ACT_RIGHT;
    applyStimulus(s);
    checkOutput("both_vel_y", int'(vel_y), -1);
    checkOutput("both_vel_x", int'(vel_x), 0);
    for (int i = 0; i < 3; i++) begin
      s = idle_stim(); s.wl = 1'b1; s.wr = 1'b1;
      applyStimulus(s);
    end
    checkOutput("vx_zero_walls", int'(vel_x), 0);

    zero_inputs();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Long rally with no english: |vel_y| must cap at MAX_SPEED.
    applyStimulus(serve_stim(2'b10));
    for (int h = 0; h < 30; h++) begin
      applyStimulus(hit_stim(ACT_NONE));
      applyStimulus(idle_stim());
      applyStimulus(idle_stim());
    end
    checkOutput("vy_sat_mag", (int'(vel_y) < 0) ? -int'(vel_y) : int'(vel_y), MAXS);

    for (int i = 0; i < 2500; i++) begin
      s = '0;
      s.miss  = ($urandom_range(0, 49) == 0);
      s.serve = ($urandom_range(0, 3) == 0);
      s.dir   = 2'($urandom_range(0, 3));
      s.ht    = ($urandom_range(0, 2) == 0);
      s.hb    = ($urandom_range(0, 2) == 0);
      s.wl    = ($urandom_range(0, 2) == 0);
      s.wr    = ($urandom_range(0, 2) == 0);
      s.at    = 2'($urandom_range(0, 3));
      s.ab    = 2'($urandom_range(0, 3));
      applyStimulus(s);
    end

    zero_inputs();
    @(posedge clk);
    #2;
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_velocity_ctrl.md
# ball_velocity_ctrl

Registered ball-velocity engine for the pong datapath. It sits between the collision detector and the ball position integrator. It holds signed x/y velocity, which it uses to:
- reflect the ball on wall and paddle hits,
- apply paddle "english" from the player's action,
- speed the ball up as the rally grows.

It generalises the per-player vector update to parametrised signed velocity, a serve/idle/hold state machine, bounce hold-off and a rally counter.

## Interface
Parameters:
- VW, 4: velocity component width, signed two's complement.
- MAX_SPEED, 7: saturation magnitude for either component; must be ≤ 2^(VW-1)-1.
- START_SPEED, 1: |vel_y| and |vel_x| applied at serve.
- HITS_PER_LEVEL, 4: paddle hits per +1 step of |vel_y|.
- HOLDOFF, 2: cycles after a paddle bounce during which paddle hits are ignored.
- CW, 8: rally counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- serve  in  1  start-of-rally pulse; honoured only in IDLE.
- serve_dir  in  2  [1] = 1 down / 0 up; [0] = 1 right / 0 left.
- miss  in  1  point scored; aborts the rally.
- hit_top, hit_bottom  in  1 each  paddle-contact strobes.
- wall_left, wall_right  in  1 each  side-wall contact strobes.
- action_top, action_bottom  in  2 each  paddle motion: 00 none, 01 left, 10 right, 11 treated as none.
- vel_x, vel_y  out  VW each  signed velocity; +x right, +y down.
- rally_count  out  CW  valid paddle hits this rally; saturates at all-ones.
- state  out  2  IDLE=0, PLAY=1, HOLD=2.

## Operation
- Reset, asynchronous: state=IDLE, vel_x=vel_y=0, rally_count=0, internal level and holdoff counters=0.
- **IDLE**
  - Velocities held at 0; all hit and wall inputs ignored.
  - serve=1 → vel_y=±START_SPEED per serve_dir[1], vel_x=±START_SPEED per serve_dir[0], rally_count=0, hit-level counter=0, go to PLAY.
- **miss**
  - In any state, miss=1 → IDLE with velocities and rally_count cleared next edge.
  - miss has priority over serve and over all hits.
- **Wall hit (PLAY or HOLD)**
  - wall_left accepted only if vel_x<0; wall_right only if vel_x>0.
  - Accepted wall hit → vel_x = -vel_x.
- **Paddle hit (PLAY only)**
  - hit_top valid only if vel_y<0; hit_bottom only if vel_y>0. Invalid strobes are ignored.
  - Valid hit → vel_y negated.
  - vel_x then adjusted by the hitting paddle's action: right +1, left -1, saturating at ±MAX_SPEED.
  - rally_count +1, saturating.
  - Level counter +1. When it reaches HITS_PER_LEVEL: counter cleared and |vel_y| +1, saturating at MAX_SPEED, sign preserved after the negation.
  - State goes to HOLD.
- **Simultaneous hits**
  - Wall and paddle in the same cycle: wall negation applied first, then the paddle action adjustment to the result.
  - hit_top and hit_bottom together: only the direction-valid one is applied.
- **HOLD**
  - Counts HOLDOFF cycles, then returns to PLAY.
  - Paddle hits are ignored; walls and miss are still processed.
- vel_x may reach 0 through action adjustment. The ball then travels vertically and wall hits are ignored until vel_x≠0.

## Timing
- All outputs are registered. Effect of any input sampled on edge N is visible after edge N.
- Serve → PLAY with velocities valid one cycle after the serve pulse.
- HOLD lasts exactly HOLDOFF cycles. A paddle strobe in the cycle the counter expires is still ignored; the first accepted one is in the cycle state=PLAY.
- Strobes are single-cycle level samples; no edge detection. A strobe held high for multiple PLAY cycles is protected only by the direction-valid rule and HOLD.
- Reset mid-rally takes effect immediately, asynchronously; no pending hit survives.

## Structure
- Shared package pong_pkg holds:
  - the state encoding constants (IDLE/PLAY/HOLD),
  - the action encodings (ACT_NONE, ACT_LEFT, ACT_RIGHT),
  - velocity-width defaults reused by the position integrator.
- One sub-module is natural: sat_add_signed, a parametrised VW-bit signed add-with-saturation to ±MAX_SPEED. It is used for the action adjustment and the speed step.
- Top level holds the FSM, the hold-off counter, the level counter and the rally counter.

## Test plan
- Reset, then serve=1 with serve_dir=2'b10 (defaults) → next cycle vel_y=+1, vel_x=-1, state=PLAY, rally_count=0.
- vel=(+1,+1) in PLAY, hit_bottom with action_bottom=10 → vel=(+2,-1), rally_count=1, state=HOLD for 2 cycles. A second hit_bottom during HOLD is ignored.
- Four valid alternating paddle hits from vel_y=+1, no action → after the 4th hit |vel_y|=2 with correct sign. With vel_y at ±7, a further level step stays at ±7.
- vel_x=+7 with right action on a paddle hit → vel_x stays +7. wall_right in the same cycle → vel_x=-6.
- hit_top while vel_y>0 → no change. hit_top and hit_bottom together with vel_y>0 → only the bottom bounce is applied.
- miss asserted during HOLD together with serve → next cycle state=IDLE, vel=(0,0), rally_count=0. Async rst_n low mid-PLAY → outputs cleared immediately.
